// File: rtl/cover_toggle_sink.sv
// Toggle-coverage sink: sticky hit bitmap with unique/dup/out-of-range counters and a word-stream dump.
// Optional build macro COVER_SINK_CLEAR_ON_DUMP_EN makes the dump destructive (bitmap words and counters cleared as read).
//
// state | meaning
// IDLE  | accepting cover events, dump_busy low
// DUMP  | streaming bitmap words, events backpressured
module cover_toggle_sink #(
    parameter int COVER_TOTAL = 38253,
    parameter int IDX_W       = 64,
    parameter int WORDS       = (COVER_TOTAL + 31) / 32,
    parameter int AW          = $clog2(WORDS)
) (
    input  logic             gbl_clk,
    input  logic             reset,
    input  logic             ev_valid,
    output logic             ev_ready,
    input  logic [IDX_W-1:0] ev_index,
    input  logic             dump_start,
    output logic             dump_busy,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [AW-1:0]    word_addr,
    output logic [31:0]      word_data,
    output logic             word_last,
    output logic [31:0]      unique_cnt,
    output logic [31:0]      dup_cnt,
    output logic [31:0]      oob_cnt
);

    typedef enum logic {IDLE, DUMP} state_t;

    localparam int          TAIL      = COVER_TOTAL - 32 * (WORDS - 1);
    localparam logic [31:0] TAIL_MASK = 32'hFFFF_FFFF >> (32 - TAIL);

    state_t      state;
    logic [31:0] bitmap [WORDS];

    logic          in_range;
    logic [AW-1:0] ev_word;
    logic [4:0]    ev_bit;
    logic          ev_hit;
    logic          accept;
    logic          word_hs;

    assign in_range = ev_index < IDX_W'(COVER_TOTAL);
    assign ev_word  = ev_index[AW+4:5];
    assign ev_bit   = ev_index[4:0];
    assign ev_hit   = bitmap[ev_word][ev_bit];
    assign accept   = ev_valid && ev_ready;
    assign word_hs  = word_valid && word_ready;

    // Bits beyond the last cover point can never be set, but mask them so the tail word is clean by construction.
    assign word_data = (word_addr == AW'(WORDS - 1)) ? (bitmap[word_addr] & TAIL_MASK)
                                                     : bitmap[word_addr];

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            state      <= IDLE;
            ev_ready   <= 1'b0;
            dump_busy  <= 1'b0;
            word_valid <= 1'b0;
            word_addr  <= '0;
            word_last  <= 1'b0;
            unique_cnt <= '0;
            dup_cnt    <= '0;
            oob_cnt    <= '0;
            for (int i = 0; i < WORDS; i++) bitmap[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!in_range) begin
                            oob_cnt <= sat_inc(oob_cnt);
                        end else if (ev_hit) begin
                            dup_cnt <= sat_inc(dup_cnt);
                        end else begin
                            bitmap[ev_word][ev_bit] <= 1'b1;
                            unique_cnt              <= sat_inc(unique_cnt);
                        end
                    end
                    if (dump_start) begin
                        state      <= DUMP;
                        ev_ready   <= 1'b0;
                        dump_busy  <= 1'b1;
                        word_valid <= 1'b1;
                        word_addr  <= '0;
                        word_last  <= (WORDS == 1);
                    end else begin
                        ev_ready <= 1'b1;
                    end
                end
                DUMP: begin
                    if (word_hs) begin
`ifdef COVER_SINK_CLEAR_ON_DUMP_EN
                        bitmap[word_addr] <= '0;
`endif
                        if (word_last) begin
                            state      <= IDLE;
                            ev_ready   <= 1'b1;
                            dump_busy  <= 1'b0;
                            word_valid <= 1'b0;
                            word_addr  <= '0;
                            word_last  <= 1'b0;
`ifdef COVER_SINK_CLEAR_ON_DUMP_EN
                            unique_cnt <= '0;
                            dup_cnt    <= '0;
                            oob_cnt    <= '0;
`endif
                        end else begin
                            word_addr <= word_addr + 1'b1;
                            word_last <= (word_addr == AW'(WORDS - 2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cover_toggle_sink.sv
// Directed bench for cover_toggle_sink: event classification, counters, dump stream, stalls and reset abort.
module tb_cover_toggle_sink;

    localparam int TOTAL = 38253;
    localparam int WORDS = 1196;
    localparam int AW    = 11;
    localparam int BUDGET = 6000;

    logic          gbl_clk = 1'b0;
    logic          reset;
    logic          ev_valid;
    logic          ev_ready;
    logic [63:0]   ev_index;
    logic          dump_start;
    logic          dump_busy;
    logic          word_valid;
    logic          word_ready;
    logic [AW-1:0] word_addr;
    logic [31:0]   word_data;
    logic          word_last;
    logic [31:0]   unique_cnt;
    logic [31:0]   dup_cnt;
    logic [31:0]   oob_cnt;

    cover_toggle_sink dut (
        .gbl_clk    (gbl_clk),
        .reset      (reset),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_index   (ev_index),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_addr  (word_addr),
        .word_data  (word_data),
        .word_last  (word_last),
        .unique_cnt (unique_cnt),
        .dup_cnt    (dup_cnt),
        .oob_cnt    (oob_cnt)
    );

    always #5 gbl_clk = ~gbl_clk;

    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] model [WORDS];
    logic [31:0] cap   [WORDS];
    int          exp_u, exp_d, exp_o;
    int          nw;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < WORDS; i++) model[i] = '0;
        exp_u = 0; exp_d = 0; exp_o = 0;
    endtask

    task automatic model_hit(input logic [63:0] idx);
        int w, b;
        if (idx < 64'(TOTAL)) begin
            w = int'(idx / 32);
            b = int'(idx % 32);
            if (model[w][b]) exp_d++;
            else begin model[w][b] = 1'b1; exp_u++; end
        end else begin
            exp_o++;
        end
    endtask

    task automatic reset_dut();
        reset = 1'b0; ev_valid = 1'b0; dump_start = 1'b0; word_ready = 1'b0; ev_index = '0;
        repeat (2) @(posedge gbl_clk);
        #1 reset = 1'b1;
        @(posedge gbl_clk); #1;
        model_clear();
    endtask

    task automatic send_ev(input logic [63:0] idx);
        ev_valid = 1'b1; ev_index = idx;
        @(posedge gbl_clk); #1;
        ev_valid = 1'b0;
        model_hit(idx);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_unique"}, unique_cnt, exp_u);
        check({tag, "_dup"}, dup_cnt, exp_d);
        check({tag, "_oob"}, oob_cnt, exp_o);
    endtask

    // Runs one dump; per-word problems are tallied and reported through a single comparison.
    task automatic run_dump(input string tag, input bit tog, input bit hold_ev, input bit sim_ev,
                            input bit pulse_mid, input int abort_at, output int nwords);
        int errs, cyc;
        bit rdy, stalled;
        logic [31:0] pd; logic [AW-1:0] pa; logic pl;
        nwords = 0; errs = 0; cyc = 0; rdy = 1'b0; stalled = 1'b0;
        pd = '0; pa = '0; pl = 1'b0;
        for (int i = 0; i < WORDS; i++) cap[i] = 32'hDEAD_BEEF;
        if (sim_ev) begin ev_valid = 1'b1; ev_index = 64'd100; model_hit(64'd100); end
        dump_start = 1'b1;
        @(posedge gbl_clk); #1;
        dump_start = 1'b0; ev_valid = 1'b0;
        if (hold_ev) begin ev_valid = 1'b1; ev_index = 64'd7; end
        while (word_valid && cyc < BUDGET) begin
            if (abort_at >= 0 && nwords == abort_at) break;
            rdy = tog ? ~rdy : 1'b1;
            word_ready = rdy;
            dump_start = pulse_mid && (nwords == 600);
            if (ev_ready !== 1'b0 || dump_busy !== 1'b1) errs++;
            if (stalled && (word_addr !== pa || word_data !== pd || word_last !== pl)) errs++;
            if (word_addr !== AW'(nwords)) errs++;
            if (nwords < WORDS && word_data !== model[nwords]) errs++;
            if (word_last !== (nwords == WORDS - 1)) errs++;
            if (rdy) begin
                if (nwords < WORDS) cap[nwords] = word_data;
                nwords++;
            end
            stalled = !rdy; pa = word_addr; pd = word_data; pl = word_last;
            @(posedge gbl_clk); #1;
            cyc++;
        end
        word_ready = 1'b0; dump_start = 1'b0;
        check({tag, "_word_errs"}, errs, 0);
        if (abort_at < 0) begin
            check({tag, "_nwords"}, nwords, WORDS);
            check({tag, "_idle_busy"}, {word_valid, dump_busy, ev_ready}, 3'b001);
            if (hold_ev) begin
                @(posedge gbl_clk); #1;
                ev_valid = 1'b0;
                model_hit(64'd7);
            end
`ifdef COVER_SINK_CLEAR_ON_DUMP_EN
            if (!hold_ev) model_clear();
            else begin model_clear(); model[0][7] = 1'b1; exp_u = 1; end
`endif
        end
    endtask

    initial begin
        reset = 1'b0; ev_valid = 1'b0; ev_index = '0; dump_start = 1'b0; word_ready = 1'b0;
        model_clear();

        // reset state
        repeat (2) @(posedge gbl_clk);
        #1;
        check("rst_ev_ready", ev_ready, 0);
        check("rst_outs", {word_valid, word_last, dump_busy, word_addr}, '0);
        check("rst_cnts", {unique_cnt, dup_cnt, oob_cnt}, '0);
        reset = 1'b1;
        @(posedge gbl_clk); #1;
        check("post_rst_ev_ready", ev_ready, 1);

        // unique hits at word boundaries and the last legal index
        send_ev(64'd0); send_ev(64'd31); send_ev(64'd32); send_ev(64'd38252);
        check("t1_unique", unique_cnt, 4);
        check_counts("t1");
        run_dump("t1", 1'b0, 1'b0, 1'b0, 1'b0, -1, nw);
        check("t1_w0", cap[0], 32'h8000_0001);
        check("t1_w1", cap[1], 32'h0000_0001);
        check("t1_w1195", cap[1195], 32'h0000_1000);

        // repeated index
        reset_dut();
        send_ev(64'd5); send_ev(64'd5); send_ev(64'd5);
        check("t2_unique", unique_cnt, 1);
        check("t2_dup", dup_cnt, 2);
        run_dump("t2", 1'b0, 1'b0, 1'b0, 1'b0, -1, nw);
        check("t2_w0", cap[0], 32'h0000_0020);

        // out-of-range indices, including full-width compare
        reset_dut();
        send_ev(64'd38253); send_ev(64'hFFFF_FFFF_FFFF_FFFF);
        check("t3_oob", oob_cnt, 2);
        check("t3_unique", unique_cnt, 0);
        run_dump("t3", 1'b0, 1'b0, 1'b0, 1'b0, -1, nw);
        check("t3_w1195", cap[1195], 32'h0);

        // stalled dump with an event held against backpressure
        reset_dut();
        send_ev(64'd3);
        run_dump("t4", 1'b1, 1'b1, 1'b0, 1'b0, -1, nw);
        check("t4_w0", cap[0], 32'h0000_0008);
        check_counts("t4");
        run_dump("t4b", 1'b0, 1'b0, 1'b0, 1'b0, -1, nw);
        check("t4_bit7", cap[0][7], 1'b1);

        // event coincident with dump_start, plus dump_start mid-dump
        reset_dut();
        run_dump("t5", 1'b0, 1'b0, 1'b1, 1'b1, -1, nw);
        check("t5_w3", cap[3], 32'h0000_0010);
        check("t5_after_idle", {word_valid, dump_busy}, 2'b00);

        // reset in the middle of a dump
        reset_dut();
        send_ev(64'd9);
        run_dump("t6", 1'b0, 1'b0, 1'b0, 1'b0, 500, nw);
        check("t6_addr", word_addr, 500);
        reset = 1'b0;
        @(posedge gbl_clk); #1;
        check("t6_abort_outs", {word_valid, dump_busy, ev_ready}, 3'b000);
        check("t6_abort_cnts", {unique_cnt, dup_cnt, oob_cnt}, '0);
        reset = 1'b1;
        @(posedge gbl_clk); #1;
        model_clear();
        check("t6_no_valid", word_valid, 0);
        run_dump("t6b", 1'b0, 1'b0, 1'b0, 1'b0, -1, nw);
        check("t6b_w0", cap[0], 32'h0);

`ifdef COVER_SINK_CLEAR_ON_DUMP_EN
        // destructive dump: second dump sees nothing
        reset_dut();
        send_ev(64'd9);
        run_dump("t7a", 1'b0, 1'b0, 1'b0, 1'b0, -1, nw);
        check("t7a_w0", cap[0], 32'h0000_0200);
        check("t7a_unique", unique_cnt, 0);
        run_dump("t7b", 1'b0, 1'b0, 1'b0, 1'b0, -1, nw);
        check("t7b_w0", cap[0], 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
